// File: rtl/pulse_pacer_pkg.sv
// pulse_pacer_pkg
//   Shared types and constants for the pulse_pacer block.
//   - state_e      : pacer FSM state (IDLE / FIRE / HOLD), 2-bit encoding
//   - ST_*_ENC     : raw encoding constants
//   - gap_w()      : width of the gap timer for a given GAP
package pulse_pacer_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_FIRE_ENC = 2'd1;
    localparam logic [1:0] ST_HOLD_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_FIRE = ST_FIRE_ENC,
        ST_HOLD = ST_HOLD_ENC
    } state_e;

    // The timer counts down from GAP-2, so $clog2(GAP) bits suffice.
    // A GAP of 2 still needs one bit to hold the value 0.
    function automatic int gap_w(input int gap);
        return (gap > 2) ? $clog2(gap) : 1;
    endfunction

endpackage

// File: rtl/pulse_pacer_gap_timer.sv
// pulse_pacer_gap_timer
//   Down-counter that enforces the spacing between paced pulses.
//   Ports:
//     clk_i      clock
//     rst_i      asynchronous active-high reset (counter -> 0)
//     load_i     load GAP-2 (asserted in the FIRE cycle)
//     dec_i      decrement by one while non-zero (asserted in HOLD)
//     expired_o  counter is zero
module pulse_pacer_gap_timer
    import pulse_pacer_pkg::*;
#(
    parameter int GAP = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic expired_o
);

    localparam int GW = gap_w(GAP);
    localparam logic [GW-1:0] LOAD_VAL = GW'(GAP - 2);

    logic [GW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - GW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_pacer.sv
// pulse_pacer
//   Accepts single-cycle event strobes (possibly back-to-back) and re-emits
//   them on sig_a as 1-cycle pulses whose rising edges are at least GAP
//   cycles apart, so a downstream toggle synchronizer into a slower clock
//   never merges events. Surplus events wait in a saturating pending counter;
//   an event that arrives while the counter is full is dropped and flagged
//   on the sticky ovf output.
//   Ports:
//     clk_a     clock (domain A)
//     rst_a     asynchronous active-high reset
//     evt_in    event strobe, one event per high cycle
//     ovf_clr   synchronous clear of ovf (a simultaneous drop wins)
//     sig_a     paced pulse, registered
//     busy      FSM not idle or events pending
//     pend      queued events not yet emitted
//     ovf       sticky drop flag
//     sent_cnt  (only with PULSE_PACER_STATS_EN) wrapping count of pulses
//   Build option: define PULSE_PACER_STATS_EN to add the sent_cnt output.
module pulse_pacer
    import pulse_pacer_pkg::*;
#(
    parameter int GAP   = 6,
    parameter int CNT_W = 4
) (
    input  logic             clk_a,
    input  logic             rst_a,
    input  logic             evt_in,
    input  logic             ovf_clr,
    output logic             sig_a,
    output logic             busy,
    output logic [CNT_W-1:0] pend,
    output logic             ovf
`ifdef PULSE_PACER_STATS_EN
    ,
    output logic [15:0]      sent_cnt
`endif
);

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             sig_q;
    logic             dispatch;
    logic             drop;
    logic             gap_load;
    logic             gap_expired;
    logic             work;

    // Something to emit this cycle: either a fresh strobe or a queued one.
    assign work = evt_in || (pend_q != '0);

    pulse_pacer_gap_timer #(
        .GAP (GAP)
    ) u_gap_timer (
        .clk_i     (clk_a),
        .rst_i     (rst_a),
        .load_i    (gap_load),
        .dec_i     (state_q == ST_HOLD),
        .expired_o (gap_expired)
    );

    // FSM next state. "dispatch" marks the decision cycle; the pulse itself
    // appears in the following (FIRE) cycle.
    always_comb begin
        state_d  = state_q;
        dispatch = 1'b0;
        gap_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (work) begin
                    dispatch = 1'b1;
                    state_d  = ST_FIRE;
                end
            end
            ST_FIRE: begin
                gap_load = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (gap_expired) begin
                    if (work) begin
                        dispatch = 1'b1;
                        state_d  = ST_FIRE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending counter: +evt_in -dispatch. Dispatch never happens with
    // pend==0 unless evt_in is also high, so there is no underflow.
    always_comb begin
        drop   = evt_in && !dispatch && (pend_q == PEND_MAX);
        pend_d = pend_q;
        if (evt_in && !dispatch && !drop) begin
            pend_d = pend_q + CNT_W'(1);
        end else if (!evt_in && dispatch) begin
            pend_d = pend_q - CNT_W'(1);
        end
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk_a or posedge rst_a) begin
        if (rst_a) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            sig_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            sig_q   <= (state_d == ST_FIRE);
        end
    end

    assign sig_a = sig_q;
    assign pend  = pend_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q != ST_IDLE) || (pend_q != '0);

`ifdef PULSE_PACER_STATS_EN
    logic [15:0] sent_q;

    always_ff @(posedge clk_a or posedge rst_a) begin
        if (rst_a)                  sent_q <= '0;
        else if (state_q == ST_FIRE) sent_q <= sent_q + 16'd1;
    end

    assign sent_cnt = sent_q;
`endif

endmodule

// File: tb/tb_pulse_pacer.sv
module tb_pulse_pacer;

    localparam int GAP   = 6;
    localparam int CNT_W = 4;
    localparam int PMAX  = (1 << CNT_W) - 1;

    logic             clk_a   = 1'b0;
    logic             rst_a   = 1'b1;
    logic             evt_in  = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             sig_a;
    logic             busy;
    logic [CNT_W-1:0] pend;
    logic             ovf;
`ifdef PULSE_PACER_STATS_EN
    logic [15:0]      sent_cnt;
`endif

    pulse_pacer #(.GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk_a    (clk_a),
        .rst_a    (rst_a),
        .evt_in   (evt_in),
        .ovf_clr  (ovf_clr),
        .sig_a    (sig_a),
        .busy     (busy),
        .pend     (pend),
        .ovf      (ovf)
`ifdef PULSE_PACER_STATS_EN
        ,
        .sent_cnt (sent_cnt)
`endif
    );

    always #5 clk_a = ~clk_a;

    int checks = 0;
    int errors = 0;

    // Reference model: the pacer is a scheduler that may emit at cycle t
    // only when there is work and at least GAP cycles have passed since the
    // previous emission decision. The pulse shows one cycle after the decision.
    int cyc;
    int m_pend;
    bit m_ovf;
    bit m_sig;
    bit m_has_last;
    int m_last;
    int m_sent;
    int pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc        = 0;
        m_pend     = 0;
        m_ovf      = 0;
        m_sig      = 0;
        m_has_last = 0;
        m_last     = 0;
        m_sent     = 0;
        pulses     = 0;
    endtask

    task automatic do_reset();
        evt_in  = 1'b0;
        ovf_clr = 1'b0;
        rst_a   = 1'b1;
        repeat (2) @(negedge clk_a);
        rst_a = 1'b0;
        model_reset();
    endtask

    // Called mid-cycle (after a negedge): check outputs of cycle cyc, drive
    // that cycle's inputs, advance the model, then move to the next cycle.
    task automatic cycle(input bit e, input bit c);
        bit disp, drop, m_busy;
        m_busy = (m_pend != 0) || (m_has_last && (cyc - m_last) <= GAP);
        chk("sig_a", sig_a, m_sig);
        chk("pend",  pend,  m_pend);
        chk("ovf",   ovf,   m_ovf);
        chk("busy",  busy,  m_busy);
`ifdef PULSE_PACER_STATS_EN
        chk("sent_cnt", sent_cnt, m_sent);
`endif
        if (sig_a === 1'b1) pulses++;
        evt_in  = e;
        ovf_clr = c;
        disp = (e || m_pend > 0) && (!m_has_last || (cyc - m_last) >= GAP);
        drop = e && !disp && (m_pend == PMAX);
        m_sent = (m_sent + int'(m_sig)) % 65536;
        m_sig  = disp;
        if (disp) begin
            m_has_last = 1;
            m_last     = cyc;
        end
        if (!drop) m_pend = m_pend + int'(e) - int'(disp);
        if (drop)   m_ovf = 1;
        else if (c) m_ovf = 0;
        cyc++;
        @(negedge clk_a);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_sig_a", sig_a, 0);
        chk("rst_pend",  pend,  0);
        chk("rst_ovf",   ovf,   0);
        chk("rst_busy",  busy,  0);

        // 1: single event at 10
        for (int i = 0; i < 30; i++) cycle(i == 10, 0);
        chk("t1_pulses", pulses, 1);

        // 2: events at 10,11,12
        do_reset();
        for (int i = 0; i < 40; i++) cycle(i >= 10 && i <= 12, 0);
        chk("t2_pulses", pulses, 3);

        // 3: 20 back-to-back events saturate the queue; clear ovf at 100
        do_reset();
        for (int i = 0; i < 200; i++) cycle(i >= 10 && i <= 29, i == 100);
        chk("t3_pulses", pulses, 19);
`ifdef PULSE_PACER_STATS_EN
        chk("t3_sent_cnt", sent_cnt, 19);
`endif

        // 4: asynchronous reset with pend=5 in HOLD discards everything
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 0);
        chk("t4_pend_before", pend, 5);
        evt_in = 1'b0;
        #2 rst_a = 1'b1;
        #1;
        chk("t4_rst_sig_a", sig_a, 0);
        chk("t4_rst_pend",  pend,  0);
        chk("t4_rst_ovf",   ovf,   0);
        chk("t4_rst_busy",  busy,  0);
        @(negedge clk_a);
        @(negedge clk_a);
        rst_a = 1'b0;
        model_reset();
        for (int i = 0; i < 50; i++) cycle(0, 0);
        chk("t4_no_pulses", pulses, 0);

        // 5: second event during the FIRE cycle
        do_reset();
        for (int i = 0; i < 30; i++) cycle(i == 10 || i == 11, 0);
        chk("t5_pulses", pulses, 2);

        // Ovf clear in the same cycle as a drop: set wins
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1, i == 35);

        // Randomized traffic with varying density
        for (int blk = 0; blk < 6; blk++) begin
            int dens;
            do_reset();
            dens = int'($urandom_range(10, 95));
            for (int i = 0; i < 150; i++)
                cycle($urandom_range(0, 99) < dens, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
